// File: rtl/lane_bank_scheduler.sv
// Round-robin shared access to a bank of per-lane value registers, plus a
// sequential scan engine that streams every lane out in index order.
// All outputs are registered; nothing combinational reaches a port.
module lane_bank_scheduler #(
  parameter int NUM_LANES = 5,
  parameter int NUM_REQ   = 3,
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      addr_err,
  input  logic                      scan_start,
  output logic                      scan_busy,
  output logic                      scan_valid,
  output logic [ADDR_W-1:0]         scan_index,
  output logic [WIDTH-1:0]          scan_data,
  output logic                      scan_done
);

  localparam int LW_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SCAN} state_t;

  state_t                           state, state_nxt;
  logic [LW_W-1:0]                  last_winner, last_winner_nxt;
  logic [ADDR_W-1:0]                scan_k, scan_k_nxt;
  logic [NUM_LANES-1:0][WIDTH-1:0]  bank;

  logic                             win_vld;
  logic [LW_W-1:0]                  win_idx;
  logic [ADDR_W-1:0]                win_addr;
  logic                             win_we;
  logic [WIDTH-1:0]                 win_wdata;
  logic                             win_in_range;

  logic                             wr_en;
  logic [NUM_REQ-1:0]               gnt_nxt;
  logic                             rd_valid_nxt;
  logic [WIDTH-1:0]                 rd_data_nxt;
  logic                             addr_err_nxt;
  logic                             scan_busy_nxt;
  logic                             scan_valid_nxt;
  logic [ADDR_W-1:0]                scan_index_nxt;
  logic [WIDTH-1:0]                 scan_data_nxt;
  logic                             scan_done_nxt;

  // Lane value lookup; addresses outside the bank read as zero.
  function automatic logic [WIDTH-1:0] lane_read(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (a == ADDR_W'(l)) v = bank[l];
    end
    return v;
  endfunction

  // Per-lane storage, each lane resetting to its own index.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [WIDTH-1:0] lane_q;
    // Lane register: written only by an in-range granted write.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        lane_q <= WIDTH'(l);
      end else if (wr_en && (win_addr == ADDR_W'(l))) begin
        lane_q <= win_wdata;
      end
    end
    assign bank[l] = lane_q;
  end

  // Round-robin pick: search from last_winner+1, first asserted req wins.
  always_comb begin
    int cand;
    cand         = 0;
    win_vld      = 1'b0;
    win_idx      = '0;
    win_addr     = '0;
    win_we       = 1'b0;
    win_wdata    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_winner) + i) % NUM_REQ;
      if (!win_vld && req[cand]) begin
        win_vld   = 1'b1;
        win_idx   = LW_W'(cand);
        win_addr  = req_addr[cand*ADDR_W +: ADDR_W];
        win_we    = req_we[cand];
        win_wdata = req_wdata[cand*WIDTH +: WIDTH];
      end
    end
    win_in_range = (int'(win_addr) < NUM_LANES);
  end

  // Next state and next registered outputs; everything defaults to idle.
  always_comb begin
    state_nxt       = state;
    last_winner_nxt = last_winner;
    scan_k_nxt      = scan_k;
    wr_en           = 1'b0;
    gnt_nxt         = '0;
    rd_valid_nxt    = 1'b0;
    rd_data_nxt     = '0;
    addr_err_nxt    = 1'b0;
    scan_busy_nxt   = 1'b0;
    scan_valid_nxt  = 1'b0;
    scan_index_nxt  = '0;
    scan_data_nxt   = '0;
    scan_done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start) begin
          // Beat 0 is presented straight out of the accepting edge.
          state_nxt      = SCAN;
          scan_k_nxt     = ADDR_W'(1);
          scan_busy_nxt  = 1'b1;
          scan_valid_nxt = 1'b1;
          scan_index_nxt = '0;
          scan_data_nxt  = lane_read('0);
        end else if (win_vld) begin
          state_nxt       = GRANT;
          last_winner_nxt = win_idx;
          for (int r = 0; r < NUM_REQ; r++) begin
            gnt_nxt[r] = (win_idx == LW_W'(r));
          end
          if (!win_in_range) begin
            addr_err_nxt = 1'b1;
          end else if (win_we) begin
            wr_en = 1'b1;
          end else begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = lane_read(win_addr);
          end
        end
      end
      GRANT: begin
        state_nxt = IDLE;
      end
      SCAN: begin
        scan_busy_nxt  = 1'b1;
        scan_valid_nxt = 1'b1;
        scan_index_nxt = scan_k;
        scan_data_nxt  = lane_read(scan_k);
        scan_k_nxt     = scan_k + 1'b1;
        if (scan_k == ADDR_W'(NUM_LANES - 1)) begin
          scan_done_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, arbitration history and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= LW_W'(NUM_REQ - 1);
      scan_k      <= '0;
      gnt         <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      addr_err    <= 1'b0;
      scan_busy   <= 1'b0;
      scan_valid  <= 1'b0;
      scan_index  <= '0;
      scan_data   <= '0;
      scan_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_winner <= last_winner_nxt;
      scan_k      <= scan_k_nxt;
      gnt         <= gnt_nxt;
      rd_valid    <= rd_valid_nxt;
      rd_data     <= rd_data_nxt;
      addr_err    <= addr_err_nxt;
      scan_busy   <= scan_busy_nxt;
      scan_valid  <= scan_valid_nxt;
      scan_index  <= scan_index_nxt;
      scan_data   <= scan_data_nxt;
      scan_done   <= scan_done_nxt;
    end
  end

endmodule

// File: tb/tb_lane_bank_scheduler.sv
// Bench for lane_bank_scheduler: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference.
module tb_lane_bank_scheduler;

  localparam int NUM_LANES = 5;
  localparam int NUM_REQ   = 3;
  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 3;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        req_we = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*WIDTH-1:0]  req_wdata = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rd_valid;
  logic [WIDTH-1:0]          rd_data;
  logic                      addr_err;
  logic                      scan_start = 1'b0;
  logic                      scan_busy;
  logic                      scan_valid;
  logic [ADDR_W-1:0]         scan_index;
  logic [WIDTH-1:0]          scan_data;
  logic                      scan_done;

  lane_bank_scheduler #(
    .NUM_LANES(NUM_LANES), .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .addr_err(addr_err),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_index(scan_index), .scan_data(scan_data), .scan_done(scan_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic               rd_valid;
    logic [WIDTH-1:0]   rd_data;
    logic               addr_err;
    logic               sv;
    logic               sb;
    logic [ADDR_W-1:0]  si;
    logic [WIDTH-1:0]   sd;
    logic               sdone;
  } rec_t;

  // Reference: a queue of the outputs promised for upcoming cycles. A new
  // decision is taken only once every promised cycle has been delivered.
  rec_t             exp_q[$];
  rec_t             cur;
  logic [WIDTH-1:0] m_bank [NUM_LANES];
  int               m_lw;

  int n_checks = 0;
  int n_pass   = 0;
  int glog[$];
  logic [WIDTH-1:0] last_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r = '{default: '0};
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NUM_LANES; k++) m_bank[k] = WIDTH'(k);
    m_lw = NUM_REQ - 1;
    exp_q.delete();
  endtask

  task automatic model_edge();
    rec_t r;
    int   best, bestd, d, a;
    if (exp_q.size() == 0) begin
      if (scan_start) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          r       = idle_rec();
          r.sv    = 1'b1;
          r.sb    = 1'b1;
          r.si    = ADDR_W'(k);
          r.sd    = m_bank[k];
          r.sdone = (k == NUM_LANES - 1);
          exp_q.push_back(r);
        end
      end else if (req != '0) begin
        // Winner is the requester nearest after the last winner, cyclically.
        best  = -1;
        bestd = NUM_REQ + 1;
        for (int c = 0; c < NUM_REQ; c++) begin
          if (req[c]) begin
            d = (c - m_lw - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (d < bestd) begin bestd = d; best = c; end
          end
        end
        r = idle_rec();
        r.gnt = NUM_REQ'(1) << best;
        a = int'(req_addr[best*ADDR_W +: ADDR_W]);
        if (a >= NUM_LANES) r.addr_err = 1'b1;
        else if (req_we[best]) m_bank[a] = req_wdata[best*WIDTH +: WIDTH];
        else begin
          r.rd_valid = 1'b1;
          r.rd_data  = m_bank[a];
        end
        m_lw = best;
        exp_q.push_back(r);
        exp_q.push_back(idle_rec());
      end else begin
        exp_q.push_back(idle_rec());
      end
    end
    cur = exp_q.pop_front();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_gnt"}, 64'(gnt), 64'(0));
    check({pfx, "_rd_valid"}, 64'(rd_valid), 64'(0));
    check({pfx, "_rd_data"}, 64'(rd_data), 64'(0));
    check({pfx, "_addr_err"}, 64'(addr_err), 64'(0));
    check({pfx, "_scan"}, 64'({scan_busy, scan_valid, scan_done}), 64'(0));
    check({pfx, "_scan_index"}, 64'(scan_index), 64'(0));
    check({pfx, "_scan_data"}, 64'(scan_data), 64'(0));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("gnt", 64'(gnt), 64'(cur.gnt));
    check("rd_valid", 64'(rd_valid), 64'(cur.rd_valid));
    check("rd_data", 64'(rd_data), 64'(cur.rd_data));
    check("addr_err", 64'(addr_err), 64'(cur.addr_err));
    check("scan_valid", 64'(scan_valid), 64'(cur.sv));
    check("scan_busy", 64'(scan_busy), 64'(cur.sb));
    check("scan_index", 64'(scan_index), 64'(cur.si));
    check("scan_data", 64'(scan_data), 64'(cur.sd));
    check("scan_done", 64'(scan_done), 64'(cur.sdone));
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) glog.push_back(r);
      if (cur.gnt[r]) req[r] = 1'b0;
    end
    if (rd_valid) last_rd = rd_data;
    scan_start = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_req(input int r, input logic we, input int a, input logic [WIDTH-1:0] d);
    req[r]                        = 1'b1;
    req_we[r]                     = we;
    req_addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(a);
    req_wdata[r*WIDTH +: WIDTH]   = d;
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_zero("reset");

    // Scan right after reset: lanes hold their indices.
    scan_start = 1'b1;
    run(7);

    // Three readers of lane 2, served in order 0, 1, 2.
    glog.delete();
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b0, 2, '0);
    run(8);
    check("order_cnt", 64'(glog.size()), 64'(3));
    for (int i = 0; i < glog.size() && i < 3; i++) check("order", 64'(glog[i]), 64'(i));

    // Write then read back through another requester.
    set_req(1, 1'b1, 3, 32'hDEAD_BEEF);
    run(3);
    set_req(0, 1'b0, 3, '0);
    last_rd = '0;
    run(3);
    check("rd_beef", 64'(last_rd), 64'(32'hDEAD_BEEF));
    scan_start = 1'b1;
    run(7);

    // Out-of-range read, then confirm bank via scan.
    set_req(2, 1'b0, 6, '0);
    run(3);
    scan_start = 1'b1;
    run(7);

    // Scan and request at the same edge: scan goes first.
    set_req(0, 1'b0, 1, '0);
    scan_start = 1'b1;
    run(9);

    // Reset in the middle of a scan after lane 0 was written.
    set_req(0, 1'b1, 0, 32'd7);
    run(3);
    scan_start = 1'b1;
    run(3);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    m_reset();
    req = '0;
    @(negedge clock);
    reset = 1'b0;
    scan_start = 1'b1;
    run(7);

    // Random traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req[r] && ($urandom % 4 == 0))
          set_req(r, 1'($urandom), int'($urandom % 8), WIDTH'($urandom));
        else if (req[r] && ($urandom % 32 == 0))
          req[r] = 1'b0;
      end
      scan_start = ($urandom % 16 == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
